// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
// Groups the register file's decode, writeback, issue and debug signals.
//   master : the pipeline side; drives addresses, write data, issue and debug
//            requests, and receives read data, stall and debug responses.
//   slave  : the register file side (opposite directions).
// Signals:
//   A1D, A2D          decode read addresses        (master -> slave)
//   RD1D, RD2D        read data                    (slave -> master)
//   RegWriteW, RdW,
//   ResultW           writeback enable/addr/data   (master -> slave)
//   IssueValidD,
//   IssueRdD          issued producer destination  (master -> slave)
//   StallD            source operand pending       (slave -> master)
//   DbgReq, DbgAddr   debug read request           (master -> slave)
//   DbgAck, DbgData   debug read response          (slave -> master)
// ---------------------------------------------------------------------------
interface register_file_if;
  logic [4:0]  A1D;
  logic [4:0]  A2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        IssueValidD;
  logic [4:0]  IssueRdD;
  logic        StallD;
  logic        DbgReq;
  logic [4:0]  DbgAddr;
  logic        DbgAck;
  logic [31:0] DbgData;

  modport master (
    output A1D, A2D, RegWriteW, RdW, ResultW, IssueValidD, IssueRdD,
           DbgReq, DbgAddr,
    input  RD1D, RD2D, StallD, DbgAck, DbgData
  );

  modport slave (
    input  A1D, A2D, RegWriteW, RdW, ResultW, IssueValidD, IssueRdD,
           DbgReq, DbgAddr,
    output RD1D, RD2D, StallD, DbgAck, DbgData
  );
endinterface

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32 x 32-bit register file (x0 hard-wired to zero) with write-through
// bypass on both read ports, a pending-write scoreboard that raises StallD
// while a decode source still awaits its producer, and a one-cycle debug
// read port.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (clears registers, scoreboard, debug)
//   bus  register_file_if.slave (decode reads, writeback, issue, debug)
// ---------------------------------------------------------------------------
module register_file (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  logic [31:0] regs_r [32];
  logic [31:0] pending_r;
  logic [31:0] pending_nxt_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;
  logic        wr_en_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] dbg_rd_s;
  logic        stall1_s;
  logic        stall2_s;
  logic        dbg_ack_r;
  logic [31:0] dbg_data_r;

  // Read rule shared by both decode ports and the debug port: x0 is zero,
  // a same-cycle writeback to the address is forwarded, else the stored value.
  function automatic logic [31:0] read_value(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        we,
    input logic [4:0]  waddr,
    input logic [31:0] wdata
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'h0000_0000;
    end else if (we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign wr_en_s = bus.RegWriteW && (bus.RdW != 5'd0);

  // Register array: cleared by reset, x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      regs_r[bus.RdW] <= bus.ResultW;
    end
  end

  // Scoreboard next state: the clear is applied first so a same-index issue
  // re-marks the register as pending for the newer producer; bit 0 stays 0.
  always_comb begin
    clr_mask_s    = bus.RegWriteW ? (32'h0000_0001 << bus.RdW) : 32'h0000_0000;
    set_mask_s    = bus.IssueValidD ? (32'h0000_0001 << bus.IssueRdD) : 32'h0000_0000;
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 32'h0000_0000;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Decode read ports and stall: a source whose producer is writing back in
  // this very cycle is served by the bypass and must not stall.
  always_comb begin
    rd1_s    = read_value(bus.A1D, regs_r[bus.A1D], bus.RegWriteW, bus.RdW, bus.ResultW);
    rd2_s    = read_value(bus.A2D, regs_r[bus.A2D], bus.RegWriteW, bus.RdW, bus.ResultW);
    dbg_rd_s = read_value(bus.DbgAddr, regs_r[bus.DbgAddr], bus.RegWriteW, bus.RdW, bus.ResultW);
    stall1_s = pending_r[bus.A1D] && !(bus.RegWriteW && (bus.RdW == bus.A1D));
    stall2_s = pending_r[bus.A2D] && !(bus.RegWriteW && (bus.RdW == bus.A2D));
  end

  // Debug response: ack pulses for the cycle after each request; data holds
  // its last captured value between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ack_r  <= 1'b0;
      dbg_data_r <= 32'h0000_0000;
    end else begin
      dbg_ack_r <= bus.DbgReq;
      if (bus.DbgReq) begin
        dbg_data_r <= dbg_rd_s;
      end else begin
        dbg_data_r <= dbg_data_r;
      end
    end
  end

  assign bus.RD1D    = rd1_s;
  assign bus.RD2D    = rd2_s;
  assign bus.StallD  = stall1_s || stall2_s;
  assign bus.DbgAck  = dbg_ack_r;
  assign bus.DbgData = dbg_data_r;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports A1D and A2D, input, 5 bits each: decode-stage read addresses.
REQ-004 SHALL have ports RD1D and RD2D, output, 32 bits each: combinational read data.
REQ-005 SHALL have ports RegWriteW (input, 1 bit), RdW (input, 5 bits) and ResultW (input, 32 bits): writeback-stage write enable, address and data.
REQ-006 SHALL have ports IssueValidD (input, 1 bit) and IssueRdD (input, 5 bits): an instruction has issued that will later write IssueRdD.
REQ-007 SHALL have port StallD, output, 1 bit: a decode source operand is still pending.
REQ-008 SHALL have ports DbgReq (input, 1 bit) and DbgAddr (input, 5 bits): debug read request.
REQ-009 SHALL have ports DbgAck (output, 1 bit) and DbgData (output, 32 bits): debug read response.

Function
REQ-010 SHALL hold 32 registers, x0..x31, each 32 bits wide, plus a 32-bit pending vector.
REQ-011 SHALL ignore any write to x0; reads of x0 SHALL return 0; pending[0] SHALL be constant 0.
REQ-012 SHALL write ResultW into register RdW at the rising edge when RegWriteW=1 and RdW!=0.
REQ-013 SHALL drive RD1D combinationally: ResultW when RegWriteW=1, RdW=A1D and A1D!=0 (write-through bypass); otherwise the value of register A1D.
REQ-014 SHALL drive RD2D by the same rule as RD1D, using A2D.
REQ-015 SHALL set pending[IssueRdD] at the edge when IssueValidD=1 and IssueRdD!=0.
REQ-016 SHALL clear pending[RdW] at the edge when RegWriteW=1.
REQ-017 SHALL resolve a same-cycle set and clear of the same index as set wins, so the pending bit stays 1 for the new producer.
REQ-018 SHALL compute StallD combinationally as the OR of pending[A1D] and pending[A2D], excluding any index currently being written: a source matching RdW with RegWriteW=1 does not stall.
REQ-019 SHALL, when DbgReq=1 at an edge, capture DbgData from register DbgAddr using write-first semantics (a same-edge write to DbgAddr is returned) and set DbgAck=1 for exactly one cycle.
REQ-020 SHALL accept back-to-back debug requests, each producing its own one-cycle DbgAck in the following cycle.
REQ-021 SHALL leave DbgData holding its last captured value while DbgAck=0.

Reset
REQ-022 SHALL, while rst=1 and regardless of clk, clear all registers to 0x00000000, the pending vector to 0, DbgAck to 0 and DbgData to 0.
REQ-023 SHALL ignore any write, issue or debug request arriving while rst=1; a pending bit set before reset SHALL read 0 after rst deasserts.
REQ-024 SHALL drive RD1D=RD2D=0 and StallD=0 for any address after reset until the first write or issue.

Verification
REQ-025 SHALL verify write then read: write x5=0x0000002A; next cycle A1D=5 -> RD1D=0x0000002A; write x0=0xFFFFFFFF, A2D=0 -> RD2D=0.
REQ-026 SHALL verify bypass: RegWriteW=1, RdW=7, ResultW=0x12345678 with A1D=7 in the same cycle -> RD1D=0x12345678 before the edge.
REQ-027 SHALL verify the scoreboard: issue rd=3; next cycle A2D=3 -> StallD=1; writeback RdW=3 in that cycle -> StallD=0 and RD2D=ResultW; the following cycle StallD=0.
REQ-028 SHALL verify set-wins: in one cycle issue rd=9 and write RdW=9 -> pending[9]=1 afterward, so A1D=9 gives StallD=1.
REQ-029 SHALL verify debug reads: DbgReq=1 with DbgAddr=5 while a same-edge write x5=0xDEADBEEF occurs -> next cycle DbgAck=1 and DbgData=0xDEADBEEF; DbgAck=0 one cycle later.
REQ-030 SHALL verify async reset: assert rst mid-cycle with pending[4]=1 and x4=0x00000011 -> StallD=0, RD1D=0 for A1D=4 and DbgAck=0 immediately, without waiting for a clock edge.
